// File: rtl/addr_gen_pkg.sv
// Shared types and defaults for the addr_gen address generator.
// ADDR_WRAP_EN (optional macro) selects windowed wrapping in addr_step.
package addr_gen_pkg;

    localparam int AW_DEF  = 8;
    localparam int BLW_DEF = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
    localparam logic [1:0] ST_BURST_ENC = 2'b01;
    localparam logic [1:0] ST_DONE_ENC  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        BURST = ST_BURST_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/addr_step.sv
// Combinational next-address adder.
// With ADDR_WRAP_EN, a sum beyond wrap_hi snaps back to wrap_lo; otherwise modulo 2^AW.
module addr_step #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] i_step,
`ifdef ADDR_WRAP_EN
    input  logic [AW-1:0] i_wrap_lo,
    input  logic [AW-1:0] i_wrap_hi,
`endif
    output logic [AW-1:0] o_next
);

`ifdef ADDR_WRAP_EN
    // Carry bit kept so an overflow past 2^AW also counts as beyond wrap_hi.
    logic [AW:0] w_sum;
    assign w_sum  = {1'b0, i_addr} + {1'b0, i_step};
    assign o_next = (w_sum > {1'b0, i_wrap_hi}) ? i_wrap_lo : w_sum[AW-1:0];
`else
    assign o_next = i_addr + i_step;
`endif

endmodule

// File: rtl/addr_gen.sv
// Address register with load, increment and handshaked strided burst mode.
// Optional ADDR_WRAP_EN adds wrap_lo/wrap_hi window ports.
module addr_gen
    import addr_gen_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int BLW = BLW_DEF
) (
    input  logic           addr_clk,
    input  logic           addr_rst,
    input  logic [AW-1:0]  addr_in,
    input  logic           addr_wr_en,
    input  logic           addr_inc,
    input  logic           burst_start,
    input  logic [BLW-1:0] burst_len,
    input  logic [AW-1:0]  burst_stride,
    input  logic           burst_ready,
`ifdef ADDR_WRAP_EN
    input  logic [AW-1:0]  wrap_lo,
    input  logic [AW-1:0]  wrap_hi,
`endif
    output logic [AW-1:0]  addr_out,
    output logic           addr_valid,
    output logic           burst_busy,
    output logic           burst_done
);

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_addr, w_addr_nxt;
    logic [BLW-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]  r_stride, w_stride_nxt;
    logic [AW-1:0]  w_step, w_next;

    // Only a burst advances by the latched stride; everything else steps by one.
    assign w_step = (r_state == BURST) ? r_stride : AW'(1);

    addr_step #(.AW(AW)) u_step (
        .i_addr    (r_addr),
        .i_step    (w_step),
`ifdef ADDR_WRAP_EN
        .i_wrap_lo (wrap_lo),
        .i_wrap_hi (wrap_hi),
`endif
        .o_next    (w_next)
    );

    always_ff @(posedge addr_clk) begin
        if (addr_rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_stride <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stride <= w_stride_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_stride_nxt = r_stride;
        case (r_state)
            IDLE: begin
                if (addr_wr_en) begin
                    w_addr_nxt = addr_in;
                end else if (burst_start) begin
                    w_cnt_nxt    = burst_len;
                    w_stride_nxt = burst_stride;
                    w_state_nxt  = BURST;
                end else if (addr_inc) begin
                    w_addr_nxt = w_next;
                end
            end
            BURST: begin
                if (addr_wr_en) begin
                    w_addr_nxt  = addr_in;
                    w_state_nxt = IDLE;
                end else if (burst_ready) begin
                    w_addr_nxt = w_next;
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                    else             w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (addr_wr_en)    w_addr_nxt = addr_in;
                else if (addr_inc) w_addr_nxt = w_next;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign addr_out   = r_addr;
    assign addr_valid = (r_state == BURST);
    assign burst_busy = (r_state == BURST);
    assign burst_done = (r_state == DONE);

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: vector table for load/increment plus
// hand-written burst, stall, abort and reset sequences, scored through a queue.
module tb_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr_in;
    logic       wr_en, inc, start, rdy;
    logic [3:0] blen;
    logic [7:0] stride;
    logic [7:0] addr_out;
    logic       valid, busy, done;
`ifdef ADDR_WRAP_EN
    logic [7:0] wlo, whi;
`endif

    always #5 clk = ~clk;

    addr_gen #(.AW(8), .BLW(4)) dut (
        .addr_clk     (clk),
        .addr_rst     (rst),
        .addr_in      (addr_in),
        .addr_wr_en   (wr_en),
        .addr_inc     (inc),
        .burst_start  (start),
        .burst_len    (blen),
        .burst_stride (stride),
        .burst_ready  (rdy),
`ifdef ADDR_WRAP_EN
        .wrap_lo      (wlo),
        .wrap_hi      (whi),
`endif
        .addr_out     (addr_out),
        .addr_valid   (valid),
        .burst_busy   (busy),
        .burst_done   (done)
    );

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic       v, b, d;
    } exp_t;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       inc;
        logic [7:0] exp_addr;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input logic w, input logic [7:0] d, input logic i,
                         input logic s, input logic [3:0] l, input logic [7:0] st,
                         input logic r);
        wr_en = w; addr_in = d; inc = i; start = s; blen = l; stride = st; rdy = r;
    endtask

    // Push the expectation for the coming edge, then score it just after the edge.
    task automatic cyc(input string nm, input logic [7:0] a, input logic v,
                       input logic b, input logic d);
        exp_t e, g;
        e.name = nm; e.addr = a; e.v = v; e.b = b; e.d = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checks++;
        if (addr_out !== g.addr || valid !== g.v || busy !== g.b || done !== g.d) begin
            errors++;
            $display("FAIL %s: got addr=%h valid=%b busy=%b done=%b, want addr=%h valid=%b busy=%b done=%b",
                     g.name, addr_out, valid, busy, done, g.addr, g.v, g.b, g.d);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 8'h3C, 1'b0, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3D};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h3E};
        vecs[3] = '{1'b1, 8'h55, 1'b1, 8'h55};
        vecs[4] = '{1'b0, 8'hAA, 1'b0, 8'h55};
        vecs[5] = '{1'b1, 8'hFF, 1'b0, 8'hFF};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h00};

`ifdef ADDR_WRAP_EN
        wlo = 8'h00; whi = 8'hFF;
`endif
        rst = 1'b1;
        drive(1'b1, 8'h77, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1);
        cyc("reset_state", 8'h00, 0, 0, 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].wr, vecs[k].din, vecs[k].inc, 1'b0, 4'd0, 8'd0, 1'b0);
            cyc($sformatf("vec%0d", k), vecs[k].exp_addr, 0, 0, 0);
        end

        // Full burst, ready held high.
        drive(1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("load_10", 8'h10, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 8'd4, 1'b1);
        cyc("b1_beat0", 8'h10, 1, 1, 0);
        start = 1'b0;
        cyc("b1_beat1", 8'h14, 1, 1, 0);
        cyc("b1_beat2", 8'h18, 1, 1, 0);
        cyc("b1_beat3", 8'h1C, 1, 1, 0);
        cyc("b1_done", 8'h20, 0, 0, 1);
        cyc("b1_idle", 8'h20, 0, 0, 0);

        // Stalled burst crossing the top of the address space.
        drive(1'b1, 8'hFE, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("load_FE", 8'hFE, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 8'd1, 1'b0);
        cyc("b2_start", 8'hFE, 1, 1, 0);
        start = 1'b0;
        cyc("b2_stall0", 8'hFE, 1, 1, 0);
        cyc("b2_stall1", 8'hFE, 1, 1, 0);
        rdy = 1'b1;
        cyc("b2_beat1", 8'hFF, 1, 1, 0);
        cyc("b2_done", 8'h00, 0, 0, 1);
        rdy = 1'b0;
        cyc("b2_idle", 8'h00, 0, 0, 0);

        // Abort after one accepted beat.
        drive(1'b1, 8'h40, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("load_40", 8'h40, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 8'd2, 1'b1);
        cyc("b3_beat0", 8'h40, 1, 1, 0);
        start = 1'b0;
        cyc("b3_beat1", 8'h42, 1, 1, 0);
        drive(1'b1, 8'h80, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        cyc("b3_abort", 8'h80, 0, 0, 0);
        wr_en = 1'b0;
        cyc("b3_no_done", 8'h80, 0, 0, 0);

        // Single-beat burst; increment honoured and start ignored in DONE.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 8'd8, 1'b1);
        cyc("b4_beat0", 8'h80, 1, 1, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 8'd8, 1'b1);
        cyc("b4_done", 8'h88, 0, 0, 1);
        cyc("b4_done_inc", 8'h89, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);

        // Reset held two cycles in the middle of a burst.
        drive(1'b1, 8'h50, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("load_50", 8'h50, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 4'd7, 8'd1, 1'b1);
        cyc("b5_beat0", 8'h50, 1, 1, 0);
        start = 1'b0;
        cyc("b5_beat1", 8'h51, 1, 1, 0);
        rst = 1'b1;
        cyc("b5_rst0", 8'h00, 0, 0, 0);
        cyc("b5_rst1", 8'h00, 0, 0, 0);
        rst = 1'b0; rdy = 1'b0;
        cyc("b5_after", 8'h00, 0, 0, 0);

`ifdef ADDR_WRAP_EN
        wlo = 8'h20; whi = 8'h23;
        drive(1'b1, 8'h22, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("w_load_22", 8'h22, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("w_inc_23", 8'h23, 0, 0, 0);
        cyc("w_inc_wrap", 8'h20, 0, 0, 0);
        drive(1'b1, 8'h40, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        cyc("w_load_40", 8'h40, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_gen.md
# addr_gen

Parametrised address generator replacing the plain 8-bit address register in the RISC SPM datapath. It holds the current memory address and supports direct load, single-step increment and a handshaked burst mode. Burst mode walks a programmable number of beats at a programmable stride, letting the controller stream memory without issuing a load per word. It sits between the control unit/bus and the memory address port.

## Interface
- AW, 8, address width in bits
- BLW, 4, burst-length field width; a burst is 1..2^BLW beats
- addr_clk  in  1  clock; all state updates on rising edge
- addr_rst  in  1  reset, synchronous, active-high
- addr_in  in  AW  load value
- addr_wr_en  in  1  load addr_in into address register
- addr_inc  in  1  single increment by 1
- burst_start  in  1  start burst at current address
- burst_len  in  BLW  beats minus one (0 → 1 beat, 2^BLW−1 → 2^BLW beats)
- burst_stride  in  AW  unsigned step between beats, added modulo 2^AW (or wrapped, see Configuration)
- burst_ready  in  1  consumer accepts current beat
- wrap_lo, wrap_hi  in  AW each  wrap window bounds (present only with ADDR_WRAP_EN)
- addr_out  out  AW  current address (register value)
- addr_valid  out  1  current address is a burst beat
- burst_busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse after last beat accepted

## Operation
- State machine with states IDLE, BURST, DONE. Reset → IDLE, addr=0, beat counter=0, latched stride=0.
- IDLE, priority addr_wr_en > burst_start > addr_inc:
  - addr_wr_en: addr ← addr_in.
  - burst_start: latch burst_len into beat counter and burst_stride into stride register; go BURST; addr unchanged (first beat = current address).
  - addr_inc: addr ← step(addr, 1).
- BURST: addr_valid=1, burst_busy=1.
  - addr_wr_en: abort; addr ← addr_in; go IDLE; no burst_done.
  - else burst_ready=1 and counter≠0: addr ← step(addr, stride); counter−1.
  - else burst_ready=1 and counter=0: addr ← step(addr, stride); go DONE.
  - burst_ready=0: hold addr and counter.
  - burst_start and addr_inc ignored.
- DONE: burst_done=1 for exactly one cycle, then IDLE. addr_wr_en and addr_inc honoured as in IDLE; burst_start ignored.
- After a burst, addr_out points one stride past the last beat.
- step(): sum computed AW+1 bits wide; default result is low AW bits (modulo wrap).

## Timing
- Reset values: addr_out=0, addr_valid=0, burst_busy=0, burst_done=0.
- Reset is synchronous and overrides all inputs in the same edge, including mid-burst (burst aborted, no done pulse).
- Load/increment/beat advance: visible on addr_out the cycle after the controlling edge (1-cycle latency).
- addr_valid, burst_busy, burst_done are decoded from registered state only; no combinational path from inputs to outputs.
- A beat transfers on any edge where addr_valid=1 and burst_ready=1; burst with ready held high takes burst_len+1 cycles in BURST plus 1 in DONE.

## Configuration
- ADDR_WRAP_EN defined: ports wrap_lo/wrap_hi present; for increment and stride steps, if AW+1-bit sum > wrap_hi (unsigned), result = wrap_lo. Loads are never wrapped. Behaviour with wrap_lo > wrap_hi is undefined.
- ADDR_WRAP_EN undefined: wrap ports absent; steps wrap modulo 2^AW.

## Structure
- Package addr_gen_pkg: state typedef (IDLE, BURST, DONE) and its encoding constants; default AW/BLW constants.
- One sub-module, addr_step: combinational next-address adder (addr, step, wrap bounds) → next address, containing the ADDR_WRAP_EN logic.

## Test plan
- Hold addr_rst 2 cycles during active burst → next cycle addr_out=0x00, addr_valid=0, burst_busy=0, burst_done=0.
- Load 0x3C, then addr_inc two cycles → addr_out 0x3C, 0x3D, 0x3E.
- addr=0x10, burst_len=3, stride=4, burst_ready=1 → valid beats 0x10,0x14,0x18,0x1C; burst_done pulse next cycle; addr_out=0x20.
- addr=0xFE, burst_len=1, stride=1, burst_ready low 2 cycles then high → 0xFE held with valid, then 0xFF, then done with addr_out=0x00 (macro off).
- Mid-burst (after 1 beat) addr_wr_en with 0x80 → next cycle addr_out=0x80, burst_busy=0, no burst_done.
- ADDR_WRAP_EN: wrap_lo=0x20, wrap_hi=0x23, addr=0x22, addr_inc twice → 0x23, 0x20; load 0x40 → 0x40 unaltered.
